alu_md: RTL and testbench

- Parametrised successor to the pipeline's combinational ALU; sits in the EX stage of the 5-stage CPU.
- Adds three things to the single-cycle logic/arith path:
  - shifts and signed/unsigned compare;
  - signed add/sub overflow detection;
  - an iterative multi-cycle multiply/divide unit with internal HI/LO registers and a stall handshake to the hazard unit.

---
 rtl/alu_md_if.sv | 29 ++
 rtl/alu_md.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_md.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_md_if.sv
// EX-stage ALU bundle: operands and op select in, combinational result, HI/LO
// and the mul/div stall handshake out.
interface alu_md_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       op;
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output A, B, op, start, flush,
        input  result, zero, overflow, hi, lo, busy, stall, done
    );

    modport slave (
        input  A, B, op, start, flush,
        output result, zero, overflow, hi, lo, busy, stall, done
    );
endinterface

// File: rtl/alu_md.sv
// Single-cycle logic/arith/shift/compare ALU plus an iterative one-bit-per-cycle
// multiply/divide unit that owns the HI/LO registers and raises stall while busy.
module alu_md #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    alu_md_if.slave  bus
);
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MULT  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [3:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   result_c;
    logic               ovf_c;

    assign a     = bus.A;
    assign b     = bus.B;
    assign op    = bus.op;
    assign shamt = a[SHAMT_W-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    always_comb begin
        result_c = '0;
        ovf_c    = 1'b0;
        case (op)
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_XOR:  result_c = a ^ b;
            OP_NOR:  result_c = ~(a | b);
            OP_ADD: begin
                result_c = sum;
                ovf_c    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result_c = diff;
                ovf_c    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  result_c = b << shamt;
            OP_SRL:  result_c = b >> shamt;
            OP_SRA:  result_c = $unsigned($signed(b) >>> shamt);
            OP_SLT:  result_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result_c = {{(WIDTH-1){1'b0}}, (a < b)};
            default: result_c = '0;
        endcase
    end

    assign bus.result   = result_c;
    assign bus.zero     = (result_c == '0);
    assign bus.overflow = ovf_c;

    // Mul/div control
    state_t             state_q, state_d;
    logic               is_md_op;
    logic               issue;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign is_md_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign issue    = bus.start && is_md_op && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue) state_d = S_CALC;
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q != S_IDLE);
        bus.done  = (state_q == S_FIX) && !bus.flush;
        bus.stall = (state_q != S_IDLE) || issue;
    end

    // Datapath: acc holds product high half / partial remainder,
    // q holds multiplier / dividend-then-quotient, m holds multiplicand / divisor.
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;

    logic               op_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = op_signed && a[WIDTH-1];
    assign sign_b    = op_signed && b[WIDTH-1];
    assign mag_a     = sign_a ? -a : a;
    assign mag_b     = sign_b ? -b : b;

    assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    assign div_shift = {acc_q, q_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, m_q};

    assign prod_fix  = neg_res_q ? -{acc_q, q_q} : {acc_q, q_q};
    assign quo_fix   = neg_res_q ? -q_q : q_q;
    assign rem_fix   = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    div0_d    = (b == '0);
                    cnt_d     = CNT_W'(WIDTH);
                    acc_d     = '0;
                    q_d       = mag_a;
                    m_d       = mag_b;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    // Restoring step: keep the trial difference only if it did not borrow.
                    if (!div_trial[WIDTH]) begin
                        acc_d = div_trial[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                if (!bus.flush) begin
                    if (is_div_q) begin
                        lo_d = div0_q ? '1 : quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed tables, hand-written abort sequences
// and randomized vectors against an arithmetic reference model.
module tb_alu_md;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_md_if #(.WIDTH(32)) bus ();

    alu_md #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } alu_vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_vec_t;

    alu_vec_t alu_tbl[14];
    md_vec_t  md_tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU: plain 64-bit arithmetic on the operand values.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ov);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        int     sh = int'(a[4:0]);
        r  = '0;
        ov = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = sa + sb; r = s[31:0]; ov = (s[32] != s[31]); end
            4'd3:  r = a ^ b;
            4'd4:  r = ~(a | b);
            4'd5:  r = b << sh;
            4'd6:  begin s = sa - sb; r = s[31:0]; ov = (s[32] != s[31]); end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd9:  r = b >> sh;
            4'd10: begin s = sb >>> sh; r = s[31:0]; end
            default: r = '0;
        endcase
    endfunction

    function automatic void ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      p;
        logic [63:0] pu;
        h = '0;
        l = '0;
        case (op)
            4'b1011: begin p = sa * sb; {h, l} = p; end
            4'b1100: begin pu = 64'(a) * 64'(b); {h, l} = pu; end
            4'b1101: begin
                if (b == 0) begin l = '1; h = a; end
                else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
            end
            4'b1110: begin
                if (b == 0) begin l = '1; h = a; end
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endfunction

    // inj_kind: 0 none, 1 flush at inj_cyc, 2 second start at inj_cyc, 3 async reset at inj_cyc.
    task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input int inj_kind,
                          input logic [31:0] exp_h, input logic [31:0] exp_l, input int exp_done);
        int dc = 0;
        @(negedge clk);
        bus.op = op; bus.A = a; bus.B = b; bus.start = 1'b1; bus.flush = 1'b0;
        #1;
        chk({name, "_issue_stall"}, bus.stall, 1);
        chk({name, "_issue_busy"}, bus.busy, 0);
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
            end
            if (c == inj_cyc) begin
                case (inj_kind)
                    1: bus.flush = 1'b1;
                    2: begin bus.start = 1'b1; bus.op = 4'b1100; bus.A = '1; bus.B = '1; end
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            if (c == inj_cyc + 1) begin
                bus.flush = 1'b0; bus.start = 1'b0; rst = 1'b0;
            end
            #1;
            if (inj_kind == 3 && c == inj_cyc) begin
                chk({name, "_rst_busy"}, bus.busy, 0);
                chk({name, "_rst_hi"}, bus.hi, 0);
                chk({name, "_rst_lo"}, bus.lo, 0);
            end
            if (inj_kind == 1 && c == inj_cyc + 1)
                chk({name, "_flush_busy"}, bus.busy, 0);
            if (bus.done && dc == 0) dc = c;
            if (dc != 0 && c == dc + 1) begin
                chk({name, "_post_busy"}, bus.busy, 0);
                chk({name, "_post_stall"}, bus.stall, 0);
            end
        end
        chk({name, "_done_cycle"}, 64'(dc), 64'(exp_done));
        chk({name, "_hi"}, bus.hi, exp_h);
        chk({name, "_lo"}, bus.lo, exp_l);
        $display("md %s op=%b a=%h b=%h hi=%h lo=%h done_cycle=%0d", name, op, a, b, bus.hi, bus.lo, dc);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'(0);
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r, h, l;
        logic        ov;
        logic [3:0]  op;
        logic [31:0] a, b;

        alu_tbl[0]  = '{4'b0000, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0000, 1'b1, 1'b0};
        alu_tbl[1]  = '{4'b0001, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0, 1'b0};
        alu_tbl[2]  = '{4'b0011, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0, 1'b0};
        alu_tbl[3]  = '{4'b0100, 32'h0000_00F0, 32'h0000_0F0F, 32'hFFFF_F000, 1'b0, 1'b0};
        alu_tbl[4]  = '{4'b0101, 32'h0000_0003, 32'h8000_0001, 32'h0000_0008, 1'b0, 1'b0};
        alu_tbl[5]  = '{4'b1001, 32'h0000_0003, 32'h8000_0001, 32'h1000_0000, 1'b0, 1'b0};
        alu_tbl[6]  = '{4'b1010, 32'h0000_0003, 32'h8000_0001, 32'hF000_0000, 1'b0, 1'b0};
        alu_tbl[7]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
        alu_tbl[8]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        alu_tbl[9]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        alu_tbl[10] = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        alu_tbl[11] = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
        alu_tbl[12] = '{4'b1011, 32'h1234_5678, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0};
        alu_tbl[13] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};

        md_tbl[0] = '{4'b1011, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        md_tbl[1] = '{4'b1100, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB};
        md_tbl[2] = '{4'b1101, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        md_tbl[3] = '{4'b1110, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        md_tbl[4] = '{4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        md_tbl[5] = '{4'b1101, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        md_tbl[6] = '{4'b1110, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

        rst = 1'b1;
        bus.A = '0; bus.B = '0; bus.op = 4'b0000; bus.start = 1'b0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_stall", bus.stall, 0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.op = alu_tbl[i].op; bus.A = alu_tbl[i].a; bus.B = alu_tbl[i].b;
            #1;
            chk($sformatf("tbl%0d_result", i), bus.result, alu_tbl[i].res);
            chk($sformatf("tbl%0d_zero", i), bus.zero, alu_tbl[i].z);
            chk($sformatf("tbl%0d_overflow", i), bus.overflow, alu_tbl[i].ov);
            $display("alu tbl%0d op=%b a=%h b=%h result=%h zero=%b ovf=%b", i, bus.op, bus.A, bus.B,
                     bus.result, bus.zero, bus.overflow);
        end

        for (int i = 0; i < 7; i++)
            run_md($sformatf("mdtbl%0d", i), md_tbl[i].op, md_tbl[i].a, md_tbl[i].b, 0, 0,
                   md_tbl[i].hi, md_tbl[i].lo, 33);

        // Last table entry left hi=2, lo=14; a flushed DIVU must leave them alone.
        run_md("flush_divu", 4'b1110, 32'd1000, 32'd3, 10, 1, 32'h0000_0002, 32'h0000_000E, 0);
        ref_md(4'b1011, 32'd12345, 32'hFFFF_FFFE, h, l);
        run_md("restart_ignored", 4'b1011, 32'd12345, 32'hFFFF_FFFE, 5, 2, h, l, 33);
        run_md("async_rst", 4'b1011, 32'hFFFF_FFFD, 32'd7, 20, 3, 32'h0, 32'h0, 0);

        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a  = pick_operand();
            b  = pick_operand();
            bus.op = op; bus.A = a; bus.B = b;
            ref_alu(op, a, b, r, ov);
            #1;
            chk($sformatf("rnd%0d_result", i), bus.result, r);
            chk($sformatf("rnd%0d_zero", i), bus.zero, (r == 0));
            chk($sformatf("rnd%0d_overflow", i), bus.overflow, ov);
            $display("alu rnd%0d op=%b a=%h b=%h result=%h", i, op, a, b, bus.result);
        end

        for (int i = 0; i < 10; i++) begin
            op = 4'($urandom_range(11, 14));
            a  = pick_operand();
            b  = pick_operand();
            ref_md(op, a, b, h, l);
            run_md($sformatf("mdrnd%0d", i), op, a, b, 0, 0, h, l, 33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
